// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC timekeeper: field widths, wrap limits and the
// packed time-of-day type used by the top level.
package rtc_pkg;

  localparam int unsigned SEC_MAX = 59;
  localparam int unsigned MIN_MAX = 59;

  localparam int unsigned SEC_W = 6;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned HR_W  = 5;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } rtc_time_t;

endpackage

// File: rtl/rtc_modn_counter.sv
// Modulo-(MAX+1) counter with synchronous load and carry-out.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset, clears q
//   inc      in   advance by one (wraps MAX -> 0)
//   load     in   synchronous load, priority over inc
//   load_val in   load value; anything above MAX loads as 0
//   q        out  current count
//   carry    out  combinational: inc while at MAX (next stage advances)
module rtc_modn_counter
  import rtc_pkg::*;
#(
  parameter int unsigned W   = SEC_W,
  parameter int unsigned MAX = SEC_MAX
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry
);

  logic [W-1:0] r_q;
  logic         w_at_max;

  assign w_at_max = (r_q == W'(MAX));
  assign carry    = inc & w_at_max;
  assign q        = r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (load) begin
      r_q <= (load_val > W'(MAX)) ? '0 : load_val;
    end else if (inc) begin
      r_q <= w_at_max ? '0 : r_q + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_timekeeper.sv
// Time-of-day counter: prescales clk to a 1-s tick and counts sec/min/hr with
// cascaded wrap, plus run/hold, synchronous time load and a minute-resolution alarm.
// Ports:
//   clk, rst_n                      clock and asynchronous active-low reset
//   run                             1 = advance, 0 = hold prescaler and time
//   load, load_sec/min/hr           synchronous time set (beats a same-cycle tick)
//   alarm_en, alarm_min, alarm_hr   alarm compare at hh:mm:00
//   sec, min, hr                    current time
//   sec_tick, day_wrap, alarm_hit   registered one-cycle strobes
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned DIV_MAX = 65535,
  parameter int unsigned HR_MAX  = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [SEC_W-1:0] load_sec,
  input  logic [MIN_W-1:0] load_min,
  input  logic [HR_W-1:0]  load_hr,
  input  logic             alarm_en,
  input  logic [MIN_W-1:0] alarm_min,
  input  logic [HR_W-1:0]  alarm_hr,
  output logic [SEC_W-1:0] sec,
  output logic [MIN_W-1:0] min,
  output logic [HR_W-1:0]  hr,
  output logic             sec_tick,
  output logic             day_wrap,
  output logic             alarm_hit
);

  logic [DIV_W-1:0] r_div;
  logic             r_sec_tick;
  logic             r_day_wrap;
  logic             r_alarm_hit;

  logic      w_tick;
  logic      w_sec_carry;
  logic      w_min_carry;
  logic      w_hr_carry;
  logic      w_alarm_match;
  rtc_time_t w_now;
  rtc_time_t w_next;

  // Load suppresses the tick so no strobe or carry fires on a time-set edge.
  assign w_tick = run & ~load & (r_div == DIV_W'(DIV_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
    end else if (load) begin
      r_div <= '0;
    end else if (run) begin
      r_div <= (r_div == DIV_W'(DIV_MAX)) ? '0 : r_div + 1'b1;
    end
  end

  rtc_modn_counter #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (w_tick),
    .load     (load),
    .load_val (load_sec),
    .q        (w_now.sec),
    .carry    (w_sec_carry)
  );

  rtc_modn_counter #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (w_sec_carry),
    .load     (load),
    .load_val (load_min),
    .q        (w_now.min),
    .carry    (w_min_carry)
  );

  // Hour carry-out is exactly the HR_MAX:59:59 -> 0:00:00 transition.
  rtc_modn_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (w_min_carry),
    .load     (load),
    .load_val (load_hr),
    .q        (w_now.hr),
    .carry    (w_hr_carry)
  );

  // Time the counters will show after this edge; the alarm compares against it so
  // the pulse lands in the cycle after the tick that reaches hh:mm:00.
  always_comb begin
    w_next = w_now;
    if (w_tick) begin
      w_next.sec = w_sec_carry ? '0 : w_now.sec + 1'b1;
      if (w_sec_carry) w_next.min = w_min_carry ? '0 : w_now.min + 1'b1;
      if (w_min_carry) w_next.hr = w_hr_carry ? '0 : w_now.hr + 1'b1;
    end
  end

  // w_next is always in range, so out-of-range alarm fields can never match.
  assign w_alarm_match = alarm_en & w_tick & (w_next.sec == '0) &
                         (w_next.min == alarm_min) & (w_next.hr == alarm_hr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sec_tick  <= 1'b0;
      r_day_wrap  <= 1'b0;
      r_alarm_hit <= 1'b0;
    end else begin
      r_sec_tick  <= w_tick;
      r_day_wrap  <= w_hr_carry;
      r_alarm_hit <= w_alarm_match;
    end
  end

  assign sec       = w_now.sec;
  assign min       = w_now.min;
  assign hr        = w_now.hr;
  assign sec_tick  = r_sec_tick;
  assign day_wrap  = r_day_wrap;
  assign alarm_hit = r_alarm_hit;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Bench for rtc_timekeeper: two instances (HR_MAX 23 and 11, DIV_MAX 3) share the
// stimulus. A seconds-of-day reference model pushes expected post-edge state into a
// scoreboard queue each cycle; entries are popped and compared after the edge.
module tb_rtc_timekeeper;

  localparam int DIVM = 3;

  logic       clk = 1'b0;
  logic       rst_n, run, load, alarm_en;
  logic [5:0] load_sec, load_min, alarm_min;
  logic [4:0] load_hr, alarm_hr;

  logic [5:0] sec_a, min_a, sec_b, min_b;
  logic [4:0] hr_a, hr_b;
  logic       tick_a, wrap_a, hit_a, tick_b, wrap_b, hit_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rtc_timekeeper #(.DIV_W(16), .DIV_MAX(DIVM), .HR_MAX(23)) dut_a (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
    .sec(sec_a), .min(min_a), .hr(hr_a),
    .sec_tick(tick_a), .day_wrap(wrap_a), .alarm_hit(hit_a)
  );

  rtc_timekeeper #(.DIV_W(16), .DIV_MAX(DIVM), .HR_MAX(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .load_sec(load_sec), .load_min(load_min), .load_hr(load_hr),
    .alarm_en(alarm_en), .alarm_min(alarm_min), .alarm_hr(alarm_hr),
    .sec(sec_b), .min(min_b), .hr(hr_b),
    .sec_tick(tick_b), .day_wrap(wrap_b), .alarm_hit(hit_b)
  );

  typedef struct {
    int inst;
    int sec, min, hr, tick, wrap, hit, div;
  } exp_t;

  exp_t sb[$];
  int   m_div[2], m_sec[2], m_min[2], m_hr[2];
  int   hr_max[2] = '{23, 11};

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_div[i] = 0; m_sec[i] = 0; m_min[i] = 0; m_hr[i] = 0;
    end
  endtask

  // Reference: time as seconds-of-day, advanced modulo the day length.
  task automatic model_edge(input int i, output exp_t e);
    int t;
    e.inst = i; e.tick = 0; e.wrap = 0; e.hit = 0;
    if (!rst_n) begin
      m_div[i] = 0; m_sec[i] = 0; m_min[i] = 0; m_hr[i] = 0;
    end else if (load) begin
      m_sec[i] = (load_sec > 59) ? 0 : int'(load_sec);
      m_min[i] = (load_min > 59) ? 0 : int'(load_min);
      m_hr[i]  = (int'(load_hr) > hr_max[i]) ? 0 : int'(load_hr);
      m_div[i] = 0;
    end else if (run) begin
      if (m_div[i] == DIVM) begin
        m_div[i] = 0;
        t = (m_hr[i] * 3600 + m_min[i] * 60 + m_sec[i] + 1) % ((hr_max[i] + 1) * 3600);
        m_hr[i]  = t / 3600;
        m_min[i] = (t / 60) % 60;
        m_sec[i] = t % 60;
        e.tick = 1;
        e.wrap = (t == 0) ? 1 : 0;
        if (alarm_en && alarm_min <= 59 && int'(alarm_hr) <= hr_max[i] &&
            t == int'(alarm_hr) * 3600 + int'(alarm_min) * 60) e.hit = 1;
      end else begin
        m_div[i]++;
      end
    end
    e.sec = m_sec[i]; e.min = m_min[i]; e.hr = m_hr[i]; e.div = m_div[i];
  endtask

  task automatic step();
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      model_edge(i, e);
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.inst == 0) begin
        chk("a_sec", int'(sec_a), e.sec);   chk("a_min", int'(min_a), e.min);
        chk("a_hr", int'(hr_a), e.hr);      chk("a_tick", int'(tick_a), e.tick);
        chk("a_wrap", int'(wrap_a), e.wrap); chk("a_hit", int'(hit_a), e.hit);
        chk("a_div", int'(dut_a.r_div), e.div);
      end else begin
        chk("b_sec", int'(sec_b), e.sec);   chk("b_min", int'(min_b), e.min);
        chk("b_hr", int'(hr_b), e.hr);      chk("b_tick", int'(tick_b), e.tick);
        chk("b_wrap", int'(wrap_b), e.wrap); chk("b_hit", int'(hit_b), e.hit);
        chk("b_div", int'(dut_b.r_div), e.div);
      end
    end
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load = 1'b1;
    load_hr = 5'(h); load_min = 6'(m); load_sec = 6'(s);
    step();
    load = 1'b0;
  endtask

  task automatic count_hits(input int n, output int hits, output int lone);
    hits = 0; lone = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (hit_a) hits++;
      if (hit_a && !tick_a) lone++;
    end
  endtask

  initial begin
    int first, second, seen59, wraps, bad, strobes, hits, lone, waited;
    int s_sec, s_min, s_hr, s_div;

    rst_n = 1'b0; run = 1'b0; load = 1'b0; alarm_en = 1'b0;
    load_sec = '0; load_min = '0; load_hr = '0; alarm_min = '0; alarm_hr = '0;
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_sec", int'(sec_a), 0); chk("rst_min", int'(min_a), 0);
    chk("rst_hr", int'(hr_a), 0);   chk("rst_tick", int'(tick_a), 0);
    chk("rst_wrap", int'(wrap_a), 0); chk("rst_hit", int'(hit_a), 0);

    // Free run from reset: ticks visible in cycles 5 and 9, sec=2 after 8 clocks.
    rst_n = 1'b1; run = 1'b1;
    first = -1; second = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick_a) begin
        if (first < 0) first = k + 1;
        else if (second < 0) second = k + 1;
      end
    end
    chk("tick_cycle_1", first, 5);
    chk("tick_cycle_2", second, 9);
    chk("sec_after_8", int'(sec_a), 2);

    // Day wrap from 23:59:58.
    do_load(23, 59, 58);
    seen59 = 0; wraps = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (sec_a == 6'd59) seen59 = 1;
      if (wrap_a) wraps++;
      if (wrap_a && !tick_a) bad++;
      if (seen59 == 0 && k == 7) bad++;
    end
    chk("wrap_saw_59", seen59, 1);
    chk("wrap_pulses", wraps, 1);
    chk("wrap_without_tick", bad, 0);
    chk("wrap_time", int'({hr_a, min_a, sec_a}), 0);

    // Load on the tick edge wins.
    for (int k = 0; k < 8 && m_div[0] != DIVM; k++) step();
    chk("align_div3", int'(dut_a.r_div), DIVM);
    do_load(10, 20, 30);
    chk("ld_hr", int'(hr_a), 10); chk("ld_min", int'(min_a), 20);
    chk("ld_sec", int'(sec_a), 30); chk("ld_no_tick", int'(tick_a), 0);
    chk("ld_div", int'(dut_a.r_div), 0);

    // Hold for 20 cycles mid-count, then resume exactly.
    step(); step();
    s_sec = int'(sec_a); s_min = int'(min_a); s_hr = int'(hr_a); s_div = int'(dut_a.r_div);
    run = 1'b0; strobes = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      strobes += int'(tick_a) + int'(wrap_a) + int'(hit_a);
    end
    chk("hold_strobes", strobes, 0);
    chk("hold_sec", int'(sec_a), s_sec); chk("hold_min", int'(min_a), s_min);
    chk("hold_hr", int'(hr_a), s_hr);    chk("hold_div", int'(dut_a.r_div), s_div);
    run = 1'b1; waited = 0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (tick_a && waited == 0) waited = k;
    end
    chk("resume_latency", waited, DIVM - s_div + 1);

    // Alarm at 07:30.
    alarm_hr = 5'd7; alarm_min = 6'd30; alarm_en = 1'b1;
    do_load(7, 29, 59);
    count_hits(6, hits, lone);
    chk("alarm_hits", hits, 1); chk("alarm_with_tick", lone, 0);
    alarm_en = 1'b0;
    do_load(7, 29, 59);
    count_hits(6, hits, lone);
    chk("alarm_disabled", hits, 0);
    alarm_en = 1'b1;
    do_load(7, 30, 0);
    count_hits(6, hits, lone);
    chk("alarm_on_load", hits, 0);
    alarm_min = 6'd60;
    do_load(7, 59, 59);
    count_hits(6, hits, lone);
    chk("alarm_out_of_range", hits, 0);
    chk("alarm_oor_hr", int'(hr_a), 8);
    alarm_en = 1'b0;

    // 12-hour instance: clamp and wrap.
    do_load(15, 0, 0);
    chk("b_clamp_hr", int'(hr_b), 0); chk("a_hr_15", int'(hr_a), 15);
    do_load(11, 59, 59);
    wraps = 0; bad = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      if (wrap_b) wraps++;
      if (wrap_a) bad++;
    end
    chk("b_wrap_pulses", wraps, 1); chk("a_no_wrap", bad, 0);
    chk("b_wrap_time", int'({hr_b, min_b, sec_b}), 0);
    chk("a_noon", int'(hr_a), 12);

    // Asynchronous reset mid-prescale.
    do_load(1, 2, 3);
    step(); step();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("arst_a_time", int'({hr_a, min_a, sec_a}), 0);
    chk("arst_b_time", int'({hr_b, min_b, sec_b}), 0);
    chk("arst_div", int'(dut_a.r_div), 0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
